// File: rtl/p6_types.sv
// Shared pipeline types: reorder-buffer entries, tags, control bits and map-table entries.
package p6_types;

  localparam int ROB_DEPTH = 16;
  localparam int ROB_TAG_W = $clog2(ROB_DEPTH) + 1;

  typedef logic [31:0] MemoryWord;

  // Tag = slot index + 1, so one extra bit is needed to reach ROB_DEPTH.
  typedef logic [ROB_TAG_W-1:0] RobSize;

  localparam RobSize ROB_TAG_NONE = '0;

  typedef struct packed {
    logic regwr;
    logic flush;
  } control_bits;

  typedef struct packed {
    logic        ready;
    logic [4:0]  rd;
    MemoryWord   value;
    control_bits ctrl_bits;
  } rob_entry;

  typedef struct packed {
    logic   busy;
    RobSize tag;
  } map_table_entry;

endpackage

// File: rtl/reorder_buffer_if.sv
// Bundle between the pipeline (master) and the reorder buffer (slave).
interface reorder_buffer_if #(
  parameter int ROB_DEPTH = p6_types::ROB_DEPTH
);
  import p6_types::rob_entry;
  import p6_types::RobSize;

  // dispatch
  logic     alloc_valid;
  rob_entry alloc_entry;
  logic     alloc_ready;
  RobSize   alloc_tag;
  // commit-stage read and writeback
  RobSize   rd_tag;
  rob_entry rd_entry;
  RobSize   wb_tag;
  rob_entry wb_entry;
  // retirement
  logic     retire_valid;
  RobSize   retire_tag;
  rob_entry retire_entry;
  logic     flush;
  logic [$clog2(ROB_DEPTH):0] count;

  modport master (
    output alloc_valid, alloc_entry, rd_tag, wb_tag, wb_entry,
    input  alloc_ready, alloc_tag, rd_entry, retire_valid, retire_tag,
           retire_entry, flush, count
  );

  modport slave (
    input  alloc_valid, alloc_entry, rd_tag, wb_tag, wb_entry,
    output alloc_ready, alloc_tag, rd_entry, retire_valid, retire_tag,
           retire_entry, flush, count
  );

endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates at the tail, accepts writebacks by tag,
// retires ready entries in order from the head, and flushes on a mispredict.
module reorder_buffer #(
  parameter int ROB_DEPTH = p6_types::ROB_DEPTH
) (
  input logic             clk,
  input logic             reset,
  reorder_buffer_if.slave bus
);
  import p6_types::rob_entry;
  import p6_types::RobSize;
  import p6_types::ROB_TAG_NONE;

  localparam int IDX_W = $clog2(ROB_DEPTH);

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [IDX_W:0]   cnt_t;

  localparam cnt_t   FULL    = cnt_t'(ROB_DEPTH);
  localparam RobSize MAX_TAG = RobSize'(ROB_DEPTH);

  rob_entry             entries [ROB_DEPTH];
  logic [ROB_DEPTH-1:0] valid;
  idx_t                 head;
  idx_t                 tail;
  cnt_t                 count_q;
  logic                 retire_valid_q;
  logic                 flush_q;
  RobSize               retire_tag_q;
  rob_entry             retire_entry_q;

  function automatic idx_t tag_to_idx(RobSize tag);
    return idx_t'(tag - RobSize'(1));
  endfunction

  function automatic RobSize idx_to_tag(idx_t idx);
    return RobSize'(idx) + RobSize'(1);
  endfunction

  // A tag addresses a live slot only if it is nonzero, in range and allocated.
  idx_t rd_idx;
  idx_t wb_idx;
  logic rd_hit;
  logic wb_hit;

  assign rd_idx = tag_to_idx(bus.rd_tag);
  assign wb_idx = tag_to_idx(bus.wb_tag);
  assign rd_hit = (bus.rd_tag != ROB_TAG_NONE) && (bus.rd_tag <= MAX_TAG) && valid[rd_idx];
  assign wb_hit = (bus.wb_tag != ROB_TAG_NONE) && (bus.wb_tag <= MAX_TAG) && valid[wb_idx];

  rob_entry head_entry;
  logic     retire_now;
  logic     flush_now;
  logic     alloc_fire;

  assign head_entry = entries[head];
  assign retire_now = valid[head] && head_entry.ready;
  assign flush_now  = retire_now && head_entry.ctrl_bits.flush;

  // Refusal while flush is high keeps dispatch from racing the cleared buffer.
  assign bus.alloc_ready = (count_q < FULL) && !flush_q;
  assign bus.alloc_tag   = idx_to_tag(tail);
  assign alloc_fire      = bus.alloc_valid && bus.alloc_ready;

  assign bus.rd_entry     = rd_hit ? entries[rd_idx] : '0;
  assign bus.retire_valid = retire_valid_q;
  assign bus.retire_tag   = retire_tag_q;
  assign bus.retire_entry = retire_entry_q;
  assign bus.flush        = flush_q;
  assign bus.count        = count_q;

  // Incoming allocations start not-ready and without a pending flush.
  rob_entry alloc_clean;
  always_comb begin
    // NOTE: every field gets a value before any override, so no latch is inferred.
    alloc_clean                 = bus.alloc_entry;
    alloc_clean.ready           = 1'b0;
    alloc_clean.ctrl_bits.flush = 1'b0;
  end

  // Entry storage: allocation at the tail, writeback by tag; both discarded on flush.
  always_ff @(posedge clk) begin
    // NOTE: the payload array has no reset; valid bits gate every read of it.
    if (!reset && !flush_now) begin
      if (alloc_fire) entries[tail]   <= alloc_clean;
      if (wb_hit)     entries[wb_idx] <= bus.wb_entry;
    end
  end

  // Control state: pointers, valid bits, occupancy and registered retire outputs.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every read sees pre-edge values.
    if (reset) begin
      valid          <= '0;
      head           <= '0;
      tail           <= '0;
      count_q        <= '0;
      retire_valid_q <= 1'b0;
      flush_q        <= 1'b0;
      retire_tag_q   <= ROB_TAG_NONE;
      retire_entry_q <= '0;
    end else begin
      retire_valid_q <= retire_now;
      flush_q        <= flush_now;
      if (retire_now) begin
        retire_tag_q   <= idx_to_tag(head);
        retire_entry_q <= head_entry;
      end
      if (flush_now) begin
        valid   <= '0;
        head    <= '0;
        tail    <= '0;
        count_q <= '0;
      end else begin
        if (retire_now) begin
          valid[head] <= 1'b0;
          head        <= head + idx_t'(1);
        end
        if (alloc_fire) begin
          valid[tail] <= 1'b1;
          tail        <= tail + idx_t'(1);
        end
        count_q <= count_q + cnt_t'(alloc_fire) - cnt_t'(retire_now);
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer.
module tb_reorder_buffer;
  import p6_types::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  reorder_buffer_if rob_bus ();

  reorder_buffer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (rob_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic rob_entry mk(logic regwr, logic fl, logic [4:0] rd, MemoryWord v, logic rdy);
    rob_entry e;
    e.ready           = rdy;
    e.rd              = rd;
    e.value           = v;
    e.ctrl_bits.regwr = regwr;
    e.ctrl_bits.flush = fl;
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rob_bus.alloc_valid = 1'b0;
    rob_bus.alloc_entry = '0;
    rob_bus.rd_tag      = '0;
    rob_bus.wb_tag      = '0;
    rob_bus.wb_entry    = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic alloc_one(input rob_entry e, input int exp_tag);
    rob_bus.alloc_valid = 1'b1;
    rob_bus.alloc_entry = e;
    #1;
    check("alloc_tag", rob_bus.alloc_tag, exp_tag);
    tick();
    rob_bus.alloc_valid = 1'b0;
  endtask

  task automatic wb(input int tag, input rob_entry e);
    rob_bus.wb_tag   = RobSize'(tag);
    rob_bus.wb_entry = e;
    tick();
    rob_bus.wb_tag   = '0;
  endtask

  task automatic read_check(input string name, input int tag, input rob_entry exp);
    rob_bus.rd_tag = RobSize'(tag);
    #1;
    check(name, rob_bus.rd_entry, exp);
    rob_bus.rd_tag = '0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle();

    // Reset state
    reset = 1'b1;
    tick();
    tick();
    check("rst_count", rob_bus.count, 0);
    check("rst_retire_valid", rob_bus.retire_valid, 0);
    check("rst_flush", rob_bus.flush, 0);
    check("rst_retire_tag", rob_bus.retire_tag, 0);
    check("rst_retire_entry", rob_bus.retire_entry, 0);
    reset = 1'b0;
    #1;
    check("rst_alloc_ready", rob_bus.alloc_ready, 1);
    check("rst_alloc_tag", rob_bus.alloc_tag, 1);

    // Three allocations; ready bit supplied high must be stored low
    for (int i = 1; i <= 3; i++) alloc_one(mk(1'b1, 1'b0, 5'(i), 32'(i * 16), 1'b1), i);
    check("count_3", rob_bus.count, 3);
    read_check("rd_tag1", 1, mk(1'b1, 1'b0, 5'd1, 32'h10, 1'b0));

    // Out-of-order writeback: tag 2 first holds retirement until tag 1 is ready
    wb(2, mk(1'b1, 1'b0, 5'd2, 32'h222, 1'b1));
    check("ooo_no_retire_a", rob_bus.retire_valid, 0);
    tick();
    check("ooo_no_retire_b", rob_bus.retire_valid, 0);
    wb(1, mk(1'b1, 1'b0, 5'd1, 32'h111, 1'b1));
    check("ooo_no_retire_c", rob_bus.retire_valid, 0);
    tick();
    check("ret1_valid", rob_bus.retire_valid, 1);
    check("ret1_tag", rob_bus.retire_tag, 1);
    check("ret1_entry", rob_bus.retire_entry, mk(1'b1, 1'b0, 5'd1, 32'h111, 1'b1));
    check("ret1_count", rob_bus.count, 2);
    tick();
    check("ret2_valid", rob_bus.retire_valid, 1);
    check("ret2_tag", rob_bus.retire_tag, 2);
    check("ret2_count", rob_bus.count, 1);
    tick();
    check("ret3_idle", rob_bus.retire_valid, 0);

    // Simultaneous allocate and retire keeps count
    wb(3, mk(1'b0, 1'b0, 5'd3, 32'h333, 1'b1));
    alloc_one(mk(1'b0, 1'b0, 5'd4, 32'h444, 1'b0), 4);
    check("simul_retire_tag", rob_bus.retire_tag, 3);
    check("simul_retire_valid", rob_bus.retire_valid, 1);
    check("simul_count", rob_bus.count, 1);

    // Fill to capacity, drop the 17th request, then wrap
    do_reset();
    for (int i = 1; i <= 16; i++) alloc_one(mk(1'b0, 1'b0, 5'd0, 32'(i), 1'b0), i);
    check("full_count", rob_bus.count, 16);
    check("full_alloc_ready", rob_bus.alloc_ready, 0);
    rob_bus.alloc_valid = 1'b1;
    rob_bus.alloc_entry = mk(1'b0, 1'b0, 5'd0, 32'hBAD, 1'b0);
    tick();
    rob_bus.alloc_valid = 1'b0;
    check("full_drop_count", rob_bus.count, 16);
    read_check("full_drop_slot", 1, mk(1'b0, 1'b0, 5'd0, 32'd1, 1'b0));
    wb(1, mk(1'b0, 1'b0, 5'd0, 32'd1, 1'b1));
    check("full_wb_no_retire", rob_bus.retire_valid, 0);
    tick();
    check("full_ret_valid", rob_bus.retire_valid, 1);
    check("full_ret_tag", rob_bus.retire_tag, 1);
    check("full_ret_count", rob_bus.count, 15);
    check("full_ret_alloc_ready", rob_bus.alloc_ready, 1);
    alloc_one(mk(1'b0, 1'b0, 5'd0, 32'h77, 1'b0), 1);
    check("wrap_count", rob_bus.count, 16);
    check("wrap_alloc_tag", rob_bus.alloc_tag, 2);
    check("wrap_alloc_ready", rob_bus.alloc_ready, 0);
    read_check("wrap_slot", 1, mk(1'b0, 1'b0, 5'd0, 32'h77, 1'b0));

    // Minimum writeback-to-retire latency
    do_reset();
    alloc_one(mk(1'b0, 1'b0, 5'd0, 32'd0, 1'b0), 1);
    wb(1, mk(1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 1'b1));
    check("lat_n1_idle", rob_bus.retire_valid, 0);
    tick();
    check("lat_n2_valid", rob_bus.retire_valid, 1);
    check("lat_n2_tag", rob_bus.retire_tag, 1);
    check("lat_n2_entry", rob_bus.retire_entry, mk(1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 1'b1));

    // Mispredict flush on tag 2
    do_reset();
    for (int i = 1; i <= 4; i++) alloc_one(mk(1'b0, 1'b0, 5'd0, 32'(i * 16), 1'b0), i);
    wb(2, mk(1'b0, 1'b1, 5'd0, 32'h2, 1'b1));
    wb(1, mk(1'b1, 1'b0, 5'd1, 32'h1, 1'b1));
    tick();
    check("fl_ret1_tag", rob_bus.retire_tag, 1);
    check("fl_ret1_flush", rob_bus.flush, 0);
    check("fl_ret1_count", rob_bus.count, 3);
    rob_bus.alloc_valid = 1'b1;
    rob_bus.alloc_entry = mk(1'b0, 1'b0, 5'd0, 32'h55, 1'b0);
    rob_bus.wb_tag      = RobSize'(3);
    rob_bus.wb_entry    = mk(1'b0, 1'b0, 5'd0, 32'h3, 1'b1);
    tick();
    idle();
    check("fl_ret2_valid", rob_bus.retire_valid, 1);
    check("fl_ret2_tag", rob_bus.retire_tag, 2);
    check("fl_ret2_flush", rob_bus.flush, 1);
    check("fl_ret2_entry", rob_bus.retire_entry, mk(1'b0, 1'b1, 5'd0, 32'h2, 1'b1));
    check("fl_count", rob_bus.count, 0);
    check("fl_alloc_ready", rob_bus.alloc_ready, 0);
    check("fl_alloc_tag", rob_bus.alloc_tag, 1);
    tick();
    check("fl_after_flush", rob_bus.flush, 0);
    check("fl_after_retire", rob_bus.retire_valid, 0);
    check("fl_after_alloc_ready", rob_bus.alloc_ready, 1);
    wb(3, mk(1'b0, 1'b0, 5'd0, 32'h3, 1'b1));
    tick();
    check("fl_wb3_ignored_retire", rob_bus.retire_valid, 0);
    check("fl_wb3_ignored_count", rob_bus.count, 0);
    read_check("fl_wb3_rd", 3, '0);

    // Writeback to an unallocated tag
    do_reset();
    for (int i = 1; i <= 3; i++) alloc_one(mk(1'b0, 1'b0, 5'd0, 32'(i), 1'b0), i);
    wb(7, mk(1'b0, 1'b0, 5'd0, 32'h7, 1'b1));
    tick();
    check("wb7_retire", rob_bus.retire_valid, 0);
    check("wb7_count", rob_bus.count, 3);
    read_check("wb7_rd7", 7, '0);
    read_check("wb7_rd1", 1, mk(1'b0, 1'b0, 5'd0, 32'd1, 1'b0));

    // Reset while a flush is pending
    do_reset();
    for (int i = 1; i <= 5; i++) alloc_one(mk(1'b0, 1'b0, 5'd0, 32'(i), 1'b0), i);
    wb(1, mk(1'b0, 1'b1, 5'd0, 32'd1, 1'b1));
    reset = 1'b1;
    rob_bus.alloc_valid = 1'b1;
    rob_bus.alloc_entry = mk(1'b0, 1'b0, 5'd0, 32'h99, 1'b0);
    tick();
    idle();
    check("rstfl_count", rob_bus.count, 0);
    check("rstfl_flush", rob_bus.flush, 0);
    check("rstfl_retire", rob_bus.retire_valid, 0);
    reset = 1'b0;
    #1;
    check("rstfl_alloc_ready", rob_bus.alloc_ready, 1);
    check("rstfl_alloc_tag", rob_bus.alloc_tag, 1);
    read_check("rstfl_rd2", 2, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

Circular reorder buffer holding in-flight instructions between dispatch and architectural retirement. Dispatch allocates entries at the tail and receives a tag. The commit stage reads an entry by tag and writes back the updated entry with `ready` and, for mispredicts, `ctrl_bits.flush` set. This block retires ready entries in program order from the head, one per cycle, and drives register-file writes, map-table release and pipeline flush.

## Interface
Parameters:
- `ROB_DEPTH`, 16: number of entries; power of two, at least 4.

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `alloc_valid` in 1: dispatch requests an entry this cycle.
- `alloc_entry` in `rob_entry`: initial contents; `ready` and `ctrl_bits.flush` are forced to 0 on write.
- `alloc_ready` out 1: buffer not full (count < `ROB_DEPTH`) and no flush pending.
- `alloc_tag` out `RobSize`: tag granted to the current request, equal to tail index + 1; valid whenever `alloc_ready` is 1.
- `rd_tag` in `RobSize`: read tag from the commit stage.
- `rd_entry` out `rob_entry`: combinational entry at `rd_tag`; all zeros when `rd_tag` is 0 or the slot is unallocated.
- `wb_tag` in `RobSize`: writeback tag; 0 means no write.
- `wb_entry` in `rob_entry`: replaces the stored entry whole.
- `retire_valid` out 1: registered; one entry retired.
- `retire_tag` out `RobSize`: tag of the retired entry; the map table clears any mapping whose tag matches it.
- `retire_entry` out `rob_entry`: contents of the retired entry. The register file writes `value` to `rd` when `ctrl_bits.regwr` is set and `rd` is nonzero.
- `flush` out 1: registered one-cycle pulse; coincides with `retire_valid` of the mispredicted branch.
- `count` out `$clog2(ROB_DEPTH)+1`: number of occupied entries.

## Operation
- State:
  - `entries[ROB_DEPTH]`
  - per-slot `valid` bit
  - `head` and `tail` indices, `$clog2(ROB_DEPTH)` bits, wrapping from `ROB_DEPTH-1` to 0
  - `count`
- Tag mapping: tag = index + 1. Tag 0 is reserved as "none", which matches the commit stage treating tag 0 as idle.
- Allocate when `alloc_valid && alloc_ready`:
  - write the entry at `tail`, set `valid`, advance `tail`.
  - `alloc_valid` while `alloc_ready` is 0 is dropped; dispatch must hold and retry.
- Writeback when `wb_tag != 0`:
  - overwrite `entries[wb_tag-1]` if that slot is valid; otherwise ignore.
  - a second writeback to an already-ready entry overwrites it (last write wins).
- Retire when `valid[head] && entries[head].ready`:
  - register `retire_*` from the head entry, clear `valid[head]`, advance `head`.
  - otherwise `retire_valid` is 0 next cycle; `retire_entry` and `retire_tag` hold their last values and are don't-care.
- Flush, when the retiring head entry has `ctrl_bits.flush` = 1:
  - the branch itself retires normally.
  - on the same edge all `valid` bits clear and `head` = `tail` = 0.
  - `flush` = 1 for the following cycle only.
  - allocation and writeback presented in the cycle the flush is decided are discarded.
  - `alloc_ready` is 0 in the cycle `flush` is high.
- Simultaneous allocate and retire: `count` is unchanged.
  - `alloc_ready` is computed from the current `count`, so a full buffer refuses allocation even while retiring.
- Writeback to the head in cycle N: the entry retires at edge N+1 (no same-cycle bypass).
- Reset:
  - all `valid` bits 0; `head`, `tail`, `count` = 0.
  - `retire_valid` = 0, `flush` = 0, `retire_tag` = 0, `retire_entry` = 0.
  - `alloc_ready` = 1, `alloc_tag` = 1.
  - Reset overrides all other activity in that cycle, including mid-flush.

## Timing
- Allocation:
  - request in cycle N; entry readable via `rd_entry` in cycle N+1.
  - `alloc_tag` is combinational from `tail`.
- Writeback is registered: presented in cycle N, visible in `rd_entry` in N+1.
- Minimum writeback-to-retire latency: `wb_tag` in cycle N, then `retire_valid` high in cycle N+2. Pipeline:
  - edge at end of N: ready stored
  - edge at end of N+1: popped and outputs registered
- Throughput: one retire per cycle and one allocation per cycle.
- `flush` is high in exactly the cycle in which `retire_valid` is high for the mispredicted branch.

## Structure
- Shared package `p6_types` holds `rob_entry`, `RobSize`, `MemoryWord`, `control_bits` and `map_table_entry`. It also gains the constants `ROB_DEPTH` and `ROB_TAG_NONE` (= 0).
- No sub-module; storage is a flat register array inside `reorder_buffer`.

## Test plan
- Reset, then allocate 3 entries: `alloc_tag` reads 1, 2, 3 and `count` = 3. Writeback tag 2 before tag 1: no retire until tag 1 is written, then tags 1 and 2 retire on consecutive cycles.
- Fill to 16 entries: `alloc_ready` = 0 and the 17th request is dropped. Retire one: `alloc_ready` = 1 and the next `alloc_tag` = 1 (wrap).
- Writeback tag 1 with `regwr` = 1, `rd` = 5, `value` = 0xDEADBEEF in cycle N: `retire_valid` is high in N+2 with `retire_tag` = 1 and `retire_entry.value` = 0xDEADBEEF.
- Entries 1–4 allocated; writeback tag 2 with `flush` = 1, then tag 1. Required response:
  - tag 1 retires, then tag 2 retires with `flush` = 1.
  - `count` = 0 afterwards and `alloc_tag` = 1.
  - a later writeback to tag 3 is ignored.
- Writeback tag 7 while only tags 1–3 are allocated: no state change and no retire.
- Assert `reset` while 5 entries are live and a flush is pending: the next cycle shows `count` = 0, `flush` = 0, `retire_valid` = 0.
